escaner_teclado: RTL
====================

# escaner_teclado

Parametrised matrix-keypad scanner for the keypad front end. Drives one column at a time and samples the row lines through a synchroniser. Debounces each press and release, then outputs a registered key code, key type and a one-cycle valid strobe. It replaces the purely combinational row/column comparator with a self-scanning, debounced block that the display and calculator logic consume directly.

## Interface
- FILAS, 4: number of row lines.
- COLS, 4: number of column lines.
- DIV_SCAN, 4: clock cycles spent on each column step; minimum 3.
- DEBOUNCE, 3: consecutive matching samples needed to accept a press or a release; minimum 1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- fil  in  FILAS  row lines, active-high, asynchronous to clk; bit FILAS-1 is row 0.
- col  out  COLS  column drive, one-hot, active-high; bit COLS-1 is column 0.
- tecla  out  clog2(FILAS*COLS)  code of the last accepted key.
- tipo  out  1  1 = digit key, 0 = function key.
- valida  out  1  one-cycle strobe marking a new tecla/tipo.

## Operation
- fil passes through a 2-flop synchroniser, giving fil_s. A period counter wraps every DIV_SCAN cycles. The sample point is the last cycle of each period.
- A sample is valid only when fil_s is one-hot. Zero rows or more than one row counts as "no key".
- FSM states:
  - ESCANEO: at each sample point, col rotates to the next column, wrapping from COLS-1 to 0. If the sample is valid, col holds, the pattern and column are latched, cnt=1, and the FSM goes to CONFIRMA. If DEBOUNCE=1, it goes straight to EMITE instead.
  - CONFIRMA: col holds. At each sample point, a sample equal to the latched pattern increments cnt. Reaching DEBOUNCE goes to EMITE. Any other sample returns to ESCANEO and advances col.
  - EMITE: lasts one cycle. Loads tecla/tipo from the latched row/column, pulses valida, clears cnt, goes to SOSTENIDA.
  - SOSTENIDA: col holds. Each zero sample increments cnt; any non-zero sample clears cnt. At cnt=DEBOUNCE, col advances and the FSM returns to ESCANEO.
- Holding a key produces exactly one strobe; there is no auto-repeat. A second key pressed while in SOSTENIDA is ignored until every key is released.
- Default code: tecla = fila_idx*COLS + col_idx. tipo = 1 when that code is ≤ 9, else 0.
- Counter widths: clog2(DIV_SCAN) and clog2(DEBOUNCE+1). Both saturate-free because the FSM clears them on every transition.

## Timing
- Reset values: col = one-hot column 0 (MSB set), tecla = 0, tipo = 0, valida = 0, FSM = ESCANEO, counters = 0, synchroniser = 0.
- rst_n low on any edge aborts an in-progress confirm or hold. The press is then lost, and no strobe is emitted after reset.
- Synchroniser latency is 2 cycles. DIV_SCAN ≥ 3 guarantees the sample reflects the currently driven column.
- valida rises the cycle after the DEBOUNCE-th matching sample point. tecla and tipo change in that same cycle and hold until the next strobe.
- Minimum press-to-strobe latency is (DEBOUNCE-1)*DIV_SCAN + 1 cycles after the first accepted sample.
- A release that bounces restarts the release count. The scan does not resume until DEBOUNCE consecutive zero samples are seen.

## Configuration
- TECLADO_MAPA_EN: compiles in the legacy 4×4 phone map. Requires FILAS=COLS=4; elaboration fails otherwise.
  - Columns 0–2, rows 0–2: digits 1..9, tipo=1.
  - Row 3: column 0 → 10 (tipo 0), column 1 → 0 (tipo 1), column 2 → 11 (tipo 0).
  - Column 3, rows 0..3: codes 0..3, tipo=0.
- Without TECLADO_MAPA_EN, the default linear code and the ≤9 tipo rule apply.

## Test plan
- Reset sequence: hold rst_n=0 for 3 cycles, then release → col=4'b1000, tecla=0, tipo=0, valida=0. col then steps 1000→0100→0010→0001→1000, one step every 4 cycles.
- Clean press, defaults: row 1 asserted on column 2 and held → exactly one valida strobe, tecla=6, tipo=1. No further strobe until release plus 3 zero samples.
- Bounce: row 0 on column 0, toggled off at the second sample then stable → no strobe from the first attempt. Strobe with tecla=0 after a fresh sequence of 3 matching samples.
- Multi-row: rows 0 and 2 asserted together on column 1 → no strobe, and col keeps rotating.
- With TECLADO_MAPA_EN: row 3 on column 1 → tecla=0, tipo=1. Row 3 on column 3 → tecla=3, tipo=0. Row 0 on column 0 → tecla=1, tipo=1.
- Reset during CONFIRMA: rst_n pulsed low after 2 matching samples → valida never rises, and all outputs return to their reset values.

Source files
------------

// File: rtl/escaner_teclado.sv
// escaner_teclado -- self-scanning, debounced matrix-keypad front end.
//
// Drives one keypad column at a time. It samples the row lines through a
// 2-flop synchroniser once per scan step. A key is accepted after DEBOUNCE
// consecutive identical one-hot samples. The block then emits a registered
// code/type pair with a one-cycle strobe. The scan resumes only after
// DEBOUNCE consecutive empty samples on the held column.
//
// Parameters:
//   FILAS    number of row lines
//   COLS     number of column lines
//   DIV_SCAN clock cycles per column step (>= 3)
//   DEBOUNCE matching samples needed to accept a press or release (>= 1)
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   synchronous reset, active-low
//   fil     row lines, active-high, asynchronous; bit FILAS-1 is row 0
//   col     one-hot column drive, active-high; bit COLS-1 is column 0
//   tecla   code of the last accepted key
//   tipo    1 = digit key, 0 = function key
//   valida  one-cycle strobe marking a new tecla/tipo
//
// Optional build macro:
//   TECLADO_MAPA_EN  legacy 4x4 phone key map. It requires FILAS = COLS = 4.
//                    Without it, tecla = row*COLS + column and
//                    tipo = (tecla <= 9).
module escaner_teclado #(
  parameter int FILAS    = 4,
  parameter int COLS     = 4,
  parameter int DIV_SCAN = 4,
  parameter int DEBOUNCE = 3,
  localparam int TW      = $clog2(FILAS * COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [FILAS-1:0] fil,
  output logic [COLS-1:0]  col,
  output logic [TW-1:0]    tecla,
  output logic             tipo,
  output logic             valida
);

  localparam int PW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (FILAS > 1) ? $clog2(FILAS) : 1;

  localparam logic [COLS-1:0] COL_INICIO = COLS'(1) << (COLS - 1);
  localparam logic [PW-1:0]   PER_ULTIMO = PW'(DIV_SCAN - 1);
  localparam logic [DW-1:0]   DEB_ULTIMO = DW'(DEBOUNCE - 1);

  if (DIV_SCAN < 3) begin : g_div_invalido
    $error("escaner_teclado: DIV_SCAN must be at least 3");
  end
  if (DEBOUNCE < 1) begin : g_deb_invalido
    $error("escaner_teclado: DEBOUNCE must be at least 1");
  end
`ifdef TECLADO_MAPA_EN
  if (FILAS != 4 || COLS != 4) begin : g_mapa_invalido
    $error("escaner_teclado: TECLADO_MAPA_EN requires a 4x4 keypad");
  end
`endif

  typedef enum logic [1:0] {ESCANEO, CONFIRMA, EMITE, SOSTENIDA} estado_t;

  estado_t          estado;
  logic [FILAS-1:0] fil_meta;
  logic [FILAS-1:0] fil_s;
  logic [FILAS-1:0] patron;
  logic [PW-1:0]    per_cnt;
  logic [DW-1:0]    cnt;
  logic [CW-1:0]    col_idx;

  logic             muestra;
  logic             una_fila;
  logic [RW-1:0]    row_idx;
  logic [COLS-1:0]  col_sig;
  logic [CW-1:0]    col_idx_sig;
  logic [TW-1:0]    code_val;
  logic             tipo_val;

  // The sample point is the last cycle of each scan step. The column
  // changed at the start of the step, so fil_s already reflects it here.
  assign muestra  = (per_cnt == PER_ULTIMO);
  // Exactly one row set; zero rows or a multi-row ghost count as no key.
  assign una_fila = (fil_s != '0) && ((fil_s & (fil_s - 1'b1)) == '0);
  assign col_sig  = (col >> 1) | (col << (COLS - 1));
  assign col_idx_sig = (col_idx == CW'(COLS - 1)) ? '0 : col_idx + 1'b1;

  always_comb begin
    row_idx = '0;
    for (int r = 0; r < FILAS; r++) begin
      if (fil_s[FILAS-1-r]) row_idx = RW'(r);
    end
  end

`ifdef TECLADO_MAPA_EN
  always_comb begin
    code_val = '0;
    tipo_val = 1'b0;
    if (col_idx == CW'(3)) begin
      // Rightmost column carries the function keys coded 0..3.
      code_val = TW'(row_idx);
      tipo_val = 1'b0;
    end else if (row_idx == RW'(3)) begin
      case (col_idx)
        CW'(0):  begin code_val = TW'(10); tipo_val = 1'b0; end
        CW'(1):  begin code_val = TW'(0);  tipo_val = 1'b1; end
        default: begin code_val = TW'(11); tipo_val = 1'b0; end
      endcase
    end else begin
      code_val = TW'(int'(row_idx) * 3 + int'(col_idx) + 1);
      tipo_val = 1'b1;
    end
  end
`else
  int lin;
  always_comb begin
    lin      = int'(row_idx) * COLS + int'(col_idx);
    code_val = TW'(lin);
    tipo_val = (lin <= 9);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado   <= ESCANEO;
      fil_meta <= '0;
      fil_s    <= '0;
      patron   <= '0;
      per_cnt  <= '0;
      cnt      <= '0;
      col_idx  <= '0;
      col      <= COL_INICIO;
      tecla    <= '0;
      tipo     <= 1'b0;
      valida   <= 1'b0;
    end else begin
      fil_meta <= fil;
      fil_s    <= fil_meta;
      per_cnt  <= muestra ? '0 : per_cnt + 1'b1;
      valida   <= 1'b0;

      case (estado)
        ESCANEO: begin
          if (muestra) begin
            if (una_fila) begin
              patron <= fil_s;
              if (DEBOUNCE == 1) begin
                tecla  <= code_val;
                tipo   <= tipo_val;
                valida <= 1'b1;
                cnt    <= '0;
                estado <= EMITE;
              end else begin
                cnt    <= DW'(1);
                estado <= CONFIRMA;
              end
            end else begin
              col     <= col_sig;
              col_idx <= col_idx_sig;
            end
          end
        end

        CONFIRMA: begin
          if (muestra) begin
            if (fil_s == patron) begin
              if (cnt == DEB_ULTIMO) begin
                // Outputs are loaded on entry so the strobe is visible
                // during the single EMITE cycle.
                tecla  <= code_val;
                tipo   <= tipo_val;
                valida <= 1'b1;
                cnt    <= '0;
                estado <= EMITE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              cnt     <= '0;
              col     <= col_sig;
              col_idx <= col_idx_sig;
              estado  <= ESCANEO;
            end
          end
        end

        EMITE: begin
          cnt    <= '0;
          estado <= SOSTENIDA;
        end

        SOSTENIDA: begin
          if (muestra) begin
            if (fil_s == '0) begin
              if (cnt == DEB_ULTIMO) begin
                cnt     <= '0;
                col     <= col_sig;
                col_idx <= col_idx_sig;
                estado  <= ESCANEO;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              // Any activity restarts the release count.
              cnt <= '0;
            end
          end
        end

        default: estado <= ESCANEO;
      endcase
    end
  end

endmodule
